multicycle_ctrl: RTL and testbench

Main control FSM for the multicycle RV32I core variant. It sequences one shared ALU, the instruction register, the PC and a single unified memory port across 3–5 cycles per instruction. It drives the 2-bit `alu_op` consumed by the existing ALU-control decoder, together with every datapath mux select and write enable. Memory accesses stall on a `mem_ready` handshake.

---
 rtl/riscv_ctrl_pkg.sv | 62 ++++++
 rtl/multicycle_ctrl_if.sv | 29 ++
 rtl/ctrl_out_decode.sv | 77 +++++++
 rtl/multicycle_ctrl.sv | 87 ++++++++
 tb/tb_multicycle_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared state encodings, opcodes, ALU op codes and datapath
// select codes for the multicycle RV32I control path.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWRITE,
        S_MEMWB,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BEQ,
        S_JAL
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic ADR_PC     = 1'b0;
    localparam logic ADR_ALUOUT = 1'b1;

    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
    } ctrl_t;

    function automatic logic is_legal(input logic [6:0] op);
        return op inside {OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BEQ, OP_JAL};
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: controller <-> datapath bundle; master is the controller.
interface multicycle_ctrl_if;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       illegal;
    logic [3:0] state_o;

    modport master (
        input  op, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_op, reg_write, illegal, state_o
    );

    modport slave (
        output op, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_op, reg_write, illegal, state_o
    );
endinterface

// File: rtl/ctrl_out_decode.sv
// ctrl_out_decode: combinational Moore decode of the control state into
// datapath selects and raw (ungated) enables.
module ctrl_out_decode
    import riscv_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.adr_src    = ADR_PC;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALU_ADD;
                ctrl.result_src = RES_ALU;
                ctrl.ir_write   = 1'b1;
                ctrl.pc_update  = 1'b1;
            end
            S_DECODE: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMREAD: begin
                ctrl.adr_src    = ADR_ALUOUT;
                ctrl.result_src = RES_ALUOUT;
            end
            S_MEMWRITE: begin
                ctrl.adr_src    = ADR_ALUOUT;
                ctrl.result_src = RES_ALUOUT;
                ctrl.mem_write  = 1'b1;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_MEMDATA;
                ctrl.reg_write  = 1'b1;
            end
            S_EXECR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_EXECI: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
            end
            S_BEQ: begin
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_RS2;
                ctrl.alu_op     = ALU_SUB;
                ctrl.result_src = RES_ALUOUT;
                ctrl.branch     = 1'b1;
            end
            S_JAL: begin
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALU_ADD;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_update  = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multicycle RV32I core.
// Define MULTICYCLE_PERF_CNT_EN to add cycle_cnt / instret_cnt outputs.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
`ifdef MULTICYCLE_PERF_CNT_EN
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt,
`endif
    multicycle_ctrl_if.master bus
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    state_t state_q, state_d;
    ctrl_t  ctrl;

    ctrl_out_decode u_dec (
        .state(state_q),
        .ctrl (ctrl)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECR;
                    OP_ITYPE:     state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: state_d = bus.mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Fetch only commits its IR/PC writes once memory delivers the word.
    assign bus.pc_write   = !reset && ((ctrl.pc_update && (bus.mem_ready || state_q != S_FETCH))
                                       || (ctrl.branch && bus.zero));
    assign bus.ir_write   = !reset && ctrl.ir_write && bus.mem_ready;
    assign bus.reg_write  = !reset && ctrl.reg_write;
    assign bus.mem_write  = !reset && ctrl.mem_write;
    assign bus.illegal    = !reset && state_q == S_DECODE && !is_legal(bus.op);
    assign bus.adr_src    = ctrl.adr_src;
    assign bus.result_src = ctrl.result_src;
    assign bus.alu_src_a  = ctrl.alu_src_a;
    assign bus.alu_src_b  = ctrl.alu_src_b;
    assign bus.alu_op     = ctrl.alu_op;
    assign bus.state_o    = state_q;

`ifdef MULTICYCLE_PERF_CNT_EN
    logic retire;

    assign retire = state_d == S_FETCH &&
                    state_q inside {S_MEMWB, S_ALUWB, S_BEQ, S_MEMWRITE};

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt   <= cycle_cnt + 1'b1;
            instret_cnt <= instret_cnt + CNT_W'(retire);
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: per-instruction phase model checked every cycle, plus
// directed literal expectations for the control sequencing.
module tb_multicycle_ctrl;
    import riscv_ctrl_pkg::*;

    typedef state_t sq_t[$];

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    multicycle_ctrl_if bus ();

`ifdef MULTICYCLE_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .cycle_cnt(cycle_cnt),
        .instret_cnt(instret_cnt), .bus(bus));
`else
    multicycle_ctrl #(.CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Phases an instruction walks through after DECODE; empty means illegal.
    function automatic sq_t route(input logic [6:0] o);
        case (o)
            7'b0000011: return '{S_MEMADR, S_MEMREAD, S_MEMWB};
            7'b0100011: return '{S_MEMADR, S_MEMWRITE};
            7'b0110011: return '{S_EXECR, S_ALUWB};
            7'b0010011: return '{S_EXECI, S_ALUWB};
            7'b1100011: return '{S_BEQ};
            7'b1101111: return '{S_JAL, S_ALUWB};
            default:    return '{};
        endcase
    endfunction

    // {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b, alu_op, reg_write, illegal}
    function automatic logic [13:0] expect_ctrl(input state_t s, input logic [6:0] o,
                                                input logic z, input logic mr, input logic rst);
        logic pcw, adr, mw, irw, rw, ill;
        logic [1:0] res, a, b, aop;
        sq_t r;
        {pcw, adr, mw, irw, rw, ill} = '0;
        {res, a, b, aop} = '0;
        r = route(o);
        case (s)
            S_FETCH:    begin b = 2'b10; res = 2'b10; irw = mr; pcw = mr; end
            S_DECODE:   begin a = 2'b01; b = 2'b01; ill = (r.size() == 0); end
            S_MEMADR:   begin a = 2'b10; b = 2'b01; end
            S_MEMREAD:  adr = 1'b1;
            S_MEMWRITE: begin adr = 1'b1; mw = 1'b1; end
            S_MEMWB:    begin res = 2'b01; rw = 1'b1; end
            S_EXECR:    begin a = 2'b10; aop = 2'b10; end
            S_EXECI:    begin a = 2'b10; b = 2'b01; aop = 2'b10; end
            S_ALUWB:    rw = 1'b1;
            S_BEQ:      begin a = 2'b10; aop = 2'b01; pcw = z; end
            S_JAL:      begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
            default:    ;
        endcase
        if (rst) {pcw, irw, rw, mw, ill} = '0;
        return {pcw, adr, mw, irw, res, a, b, aop, rw, ill};
    endfunction

    state_t      m_state = S_FETCH;
    sq_t         m_rest;
    int unsigned m_cc = 0;
    int unsigned m_ic = 0;

    task automatic advance();
        if (m_rest.size() != 0) m_state = m_rest.pop_front();
        else begin
            m_state = S_FETCH;
            m_ic++;
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_state = S_FETCH;
            m_rest.delete();
            m_cc = 0;
            m_ic = 0;
        end else begin
            m_cc++;
            case (m_state)
                S_FETCH: if (bus.mem_ready) m_state = S_DECODE;
                S_DECODE: begin
                    m_rest = route(bus.op);
                    if (m_rest.size() == 0) m_state = S_FETCH;
                    else m_state = m_rest.pop_front();
                end
                S_MEMREAD, S_MEMWRITE: if (bus.mem_ready) advance();
                default: advance();
            endcase
        end
    end

    initial forever begin
        @(negedge clk);
        check("state", {28'h0, bus.state_o}, {28'h0, 4'(m_state)});
        check("ctrl", {18'h0, bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write,
                       bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                       bus.reg_write, bus.illegal},
              {18'h0, expect_ctrl(m_state, bus.op, bus.zero, bus.mem_ready, reset)});
`ifdef MULTICYCLE_PERF_CNT_EN
        check("cycle_cnt", cycle_cnt, m_cc);
        check("instret_cnt", instret_cnt, m_ic);
`endif
    end

    logic [3:0]  h_st [40];
    logic        h_rw [40], h_pcw [40], h_irw [40], h_mw [40], h_ill [40], h_adr [40];
    logic [1:0]  h_aop [40], h_b [40];
    logic [31:0] h_cc [40], h_ic [40];

    function automatic int ones(input logic a [40], input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += int'(a[i]);
        return s;
    endfunction

    // Runs one instruction from FETCH back to FETCH; reset asserted in cycle rst_at.
    task automatic run(input logic [6:0] o, input int waits, input logic z,
                       input int rst_at, output int n);
        bit done = 0;
        int w = waits;
        bus.op = o;
        n = 0;
        while (!done && n < 40) begin
            reset = (n == rst_at);
            if ((bus.state_o == 4'(S_MEMREAD) || bus.state_o == 4'(S_MEMWRITE)) && w > 0) begin
                bus.mem_ready = 1'b0;
                w--;
            end else bus.mem_ready = 1'b1;
            bus.zero = z;
            @(negedge clk);
            h_st[n] = bus.state_o;   h_rw[n] = bus.reg_write;  h_pcw[n] = bus.pc_write;
            h_irw[n] = bus.ir_write; h_mw[n] = bus.mem_write;  h_ill[n] = bus.illegal;
            h_adr[n] = bus.adr_src;  h_aop[n] = bus.alu_op;    h_b[n] = bus.alu_src_b;
`ifdef MULTICYCLE_PERF_CNT_EN
            h_cc[n] = cycle_cnt;     h_ic[n] = instret_cnt;
`else
            h_cc[n] = 0;             h_ic[n] = 0;
`endif
            n++;
            @(posedge clk);
            #1;
            done = (bus.state_o == 4'(S_FETCH));
        end
        reset = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout op=%b: no return to FETCH within %0d cycles", o, n);
        end
    endtask

    initial begin
        int n;
        reset = 1'b1;
        bus.op = OP_RTYPE;
        bus.mem_ready = 1'b1;
        bus.zero = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_state", {28'h0, bus.state_o}, 32'h0);
        check("rst_ir_write", {31'h0, bus.ir_write}, 32'h0);
        check("rst_pc_write", {31'h0, bus.pc_write}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check("stall_ir_write", {31'h0, bus.ir_write}, 32'h0);
        check("stall_pc_write", {31'h0, bus.pc_write}, 32'h0);
        @(posedge clk); #1;
        check("stall_hold", {28'h0, bus.state_o}, 32'h0);

        run(OP_RTYPE, 0, 1'b0, -1, n);
        check("r_cycles", n, 4);
        check("r_fetch_ir", {31'h0, h_irw[0]}, 32'h1);
        check("r_fetch_pc", {31'h0, h_pcw[0]}, 32'h1);
        check("r_fetch_srcb", {30'h0, h_b[0]}, 32'h2);
        check("r_exec_aluop", {30'h0, h_aop[2]}, 32'h2);
        check("r_wb_cycle", {31'h0, h_rw[3]}, 32'h1);
        check("r_wb_count", ones(h_rw, n), 1);

        run(OP_LW, 2, 1'b0, -1, n);
        check("lw_cycles", n, 7);
        check("lw_adr_src", ones(h_adr, n), 3);
        check("lw_wb_cycle", {31'h0, h_rw[6]}, 32'h1);
        check("lw_wb_count", ones(h_rw, n), 1);

        run(OP_BEQ, 0, 1'b1, -1, n);
        check("beq_cycles", n, 3);
        check("beq_taken_pc", {31'h0, h_pcw[2]}, 32'h1);
        check("beq_aluop", {30'h0, h_aop[2]}, 32'h1);
        run(OP_BEQ, 0, 1'b0, -1, n);
        check("beq_not_taken_pc", {31'h0, h_pcw[2]}, 32'h0);

        run(7'b0000000, 0, 1'b0, -1, n);
        check("ill_cycles", n, 2);
        check("ill_pulse", {31'h0, h_ill[1]}, 32'h1);
        check("ill_count", ones(h_ill, n), 1);
        check("ill_no_writes", ones(h_rw, n) + ones(h_mw, n) + int'(h_pcw[1]) + int'(h_irw[1]), 0);

        run(OP_SW, 1, 1'b0, -1, n);
        check("sw_cycles", n, 5);
        check("sw_mem_write_held", ones(h_mw, n), 2);

        run(OP_JAL, 0, 1'b0, -1, n);
        check("jal_cycles", n, 4);
        check("jal_pc_writes", ones(h_pcw, n), 2);
        check("jal_wb", {31'h0, h_rw[3]}, 32'h1);

        run(OP_ITYPE, 0, 1'b0, -1, n);
        check("i_cycles", n, 4);

`ifdef MULTICYCLE_PERF_CNT_EN
        run(OP_RTYPE, 0, 1'b0, 0, n);
        run(OP_SW, 0, 1'b0, -1, n);
        run(OP_JAL, 0, 1'b0, -1, n);
        run(OP_ITYPE, 0, 1'b0, 2, n);
        check("perf_cycle_cnt", h_cc[0], 32'd8);
        check("perf_instret_cnt", h_ic[0], 32'd2);
        check("perf_abort_cycles", n, 3);
        check("perf_abort_no_wb", ones(h_rw, n), 0);
        run(OP_RTYPE, 0, 1'b0, -1, n);
        check("perf_cycle_cleared", h_cc[0], 32'd0);
        check("perf_instret_cleared", h_ic[0], 32'd0);
`endif

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
